// File: rtl/alu_result_queue_pkg.sv
// alu_result_queue_pkg: flag indices, ALU opcodes and the stored entry layout
// shared by the result queue and the ALU.
package alu_result_queue_pkg;
   localparam int FLAG_ZERO   = 0;
   localparam int FLAG_CARRY  = 1;
   localparam int FLAG_BORROW = 2;
   localparam int FLAG_OVF    = 3;
   localparam int FLAGS_W     = 4;
   localparam int ENTRY_W     = 15;
   localparam logic [2:0] OP_ADD  = 3'd0;
   localparam logic [2:0] OP_SUB  = 3'd1;
   localparam logic [2:0] OP_AND  = 3'd2;
   localparam logic [2:0] OP_OR   = 3'd3;
   localparam logic [2:0] OP_XOR  = 3'd4;
   localparam logic [2:0] OP_SHL  = 3'd5;
   localparam logic [2:0] OP_SHR  = 3'd6;
   localparam logic [2:0] OP_PASS = 3'd7;
   typedef struct packed {
      logic [2:0]         opcode;
      logic [7:0]         result;
      logic [FLAGS_W-1:0] flags;
   } entry_t;
   function automatic logic [FLAGS_W-1:0] pack_flags(input logic zero, carry, borrow, ovf);
      logic [FLAGS_W-1:0] f;
      f              = '0;
      f[FLAG_ZERO]   = zero;
      f[FLAG_CARRY]  = carry;
      f[FLAG_BORROW] = borrow;
      f[FLAG_OVF]    = ovf;
      return f;
   endfunction
endpackage

// File: rtl/alu_result_queue_mem.sv
// alu_result_queue_mem: DEPTH x ENTRY_W register array, synchronous write,
// asynchronous read; contents are never reset.
module alu_result_queue_mem
   import alu_result_queue_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                     clk,
   input  logic                     we,
   input  logic [$clog2(DEPTH)-1:0] waddr,
   input  logic [ENTRY_W-1:0]       wdata,
   input  logic [$clog2(DEPTH)-1:0] raddr,
   output logic [ENTRY_W-1:0]       rdata
);
   logic [ENTRY_W-1:0] mem [DEPTH];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   assign rdata = mem[raddr];
endmodule

// File: rtl/alu_result_queue.sv
// alu_result_queue: in-order FIFO of ALU results with sticky flag
// accumulation and a saturating overflow counter.
module alu_result_queue
   import alu_result_queue_pkg::*;
#(
   parameter int         DEPTH   = 4,
   parameter logic [7:0] SAT_MAX = 8'hFF
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [2:0]             in_opcode,
   input  logic [7:0]             in_result,
   input  logic                   in_carry,
   input  logic                   in_borrow,
   input  logic                   in_zero,
   input  logic                   in_overflow,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [2:0]             out_opcode,
   output logic [7:0]             out_result,
   output logic [3:0]             out_flags,
   output logic [$clog2(DEPTH):0] count,
   input  logic                   clr_sticky,
   output logic [3:0]             sticky_flags,
   output logic [7:0]             ovf_count
);
   localparam int AW = $clog2(DEPTH);
   logic [AW-1:0]      wr_ptr, rd_ptr;
   logic               push, pop;
   logic [FLAGS_W-1:0] new_flags;
   entry_t             wdata, rdata;
   assign in_ready  = count != (AW+1)'(DEPTH);
   assign out_valid = count != '0;
   assign push      = in_valid && in_ready;
   assign pop       = out_valid && out_ready;
   assign new_flags = pack_flags(in_zero, in_carry, in_borrow, in_overflow);
   assign wdata     = '{opcode: in_opcode, result: in_result, flags: new_flags};
   assign out_opcode = rdata.opcode;
   assign out_result = rdata.result;
   assign out_flags  = rdata.flags;
   alu_result_queue_mem #(.DEPTH(DEPTH)) u_mem (
      .clk   (clk),
      .we    (push),
      .waddr (wr_ptr),
      .wdata (wdata),
      .raddr (rd_ptr),
      .rdata (rdata)
   );
   // Pointers are exactly AW bits, so DEPTH-1 wraps to 0 by overflow.
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(push);
         rd_ptr <= rd_ptr + AW'(pop);
         count  <= count + (AW+1)'(push) - (AW+1)'(pop);
      end
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         sticky_flags <= '0;
         ovf_count    <= '0;
      end else if (clr_sticky) begin
         sticky_flags <= push ? new_flags : '0;
         ovf_count    <= {7'd0, push && in_overflow};
      end else if (push) begin
         sticky_flags <= sticky_flags | new_flags;
         ovf_count    <= (in_overflow && ovf_count != SAT_MAX) ? ovf_count + 8'd1 : ovf_count;
      end
endmodule

// File: tb/tb_alu_result_queue.sv
// tb_alu_result_queue: scoreboard bench; expected entries are queued on
// accepted pushes and compared against the head on every cycle it is valid.
module tb_alu_result_queue;
   import alu_result_queue_pkg::*;
   localparam int DEPTH = 4;
   logic       clk = 1'b0, rst_n = 1'b0;
   logic       in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, clr_sticky = 1'b0;
   logic [2:0] in_opcode = '0, out_opcode;
   logic [7:0] in_result = '0, out_result, ovf_count;
   logic       in_carry = 1'b0, in_borrow = 1'b0, in_zero = 1'b0, in_overflow = 1'b0;
   logic [3:0] out_flags, sticky_flags;
   logic [2:0] count;
   logic [14:0] q[$];
   logic [3:0]  sticky_m = '0;
   logic [7:0]  ovf_m = '0;
   int n_chk = 0, n_err = 0;

   alu_result_queue #(.DEPTH(DEPTH), .SAT_MAX(8'hFF)) dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .in_opcode(in_opcode), .in_result(in_result), .in_carry(in_carry),
      .in_borrow(in_borrow), .in_zero(in_zero), .in_overflow(in_overflow),
      .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode),
      .out_result(out_result), .out_flags(out_flags), .count(count),
      .clr_sticky(clr_sticky), .sticky_flags(sticky_flags), .ovf_count(ovf_count)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // One clock: check handshake and head at negedge, then update model after posedge.
   task automatic cyc();
      logic       psh, pp;
      logic [3:0] nf;
      @(negedge clk);
      check("in_ready", in_ready, q.size() != DEPTH);
      check("out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) check("head", {out_opcode, out_result, out_flags}, q[0]);
      psh = in_valid && q.size() != DEPTH;
      pp  = out_ready && q.size() != 0;
      nf  = {in_overflow, in_borrow, in_carry, in_zero};
      @(posedge clk);
      #1;
      if (pp) q.delete(0);
      if (psh) q.push_back({in_opcode, in_result, nf});
      if (clr_sticky) begin
         sticky_m = psh ? nf : 4'd0;
         ovf_m    = (psh && in_overflow) ? 8'd1 : 8'd0;
      end else if (psh) begin
         sticky_m = sticky_m | nf;
         if (in_overflow && ovf_m != 8'hFF) ovf_m = ovf_m + 8'd1;
      end
      check("count", count, q.size());
      check("sticky", sticky_flags, sticky_m);
      check("ovf_count", ovf_count, ovf_m);
   endtask

   // f is {overflow, borrow, carry, zero}
   task automatic drv(input logic v, input logic [2:0] op, input logic [7:0] res,
                      input logic [3:0] f, input logic ordy, input logic clr);
      in_valid = v; in_opcode = op; in_result = res;
      {in_overflow, in_borrow, in_carry, in_zero} = f;
      out_ready = ordy; clr_sticky = clr;
      cyc();
   endtask

   initial begin
      #2;
      check("rst_count", count, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_out_valid", out_valid, 0);
      check("rst_sticky", sticky_flags, 0);
      check("rst_ovf", ovf_count, 0);
      #10 rst_n = 1'b1;
      @(posedge clk);
      #1;
      drv(1, OP_ADD, 8'h80, 4'b1000, 0, 0);
      check("first_ovf", ovf_count, 1);
      check("first_sticky", sticky_flags, 4'b1000);
      drv(0, 0, 0, 0, 0, 0);
      check("first_result", out_result, 8'h80);
      check("first_flags", out_flags, 4'b1000);
      drv(0, 0, 0, 0, 1, 1);
      for (int i = 1; i <= 5; i++) drv(1, OP_SUB, 8'(i), 4'b0010, 0, 0);
      check("full_count", count, 4);
      check("full_in_ready", in_ready, 0);
      for (int i = 0; i < 5; i++) drv(0, 0, 0, 0, 1, 0);
      check("drained_valid", out_valid, 0);
      for (int i = 0; i < 2; i++) drv(1, OP_AND, 8'h10 + 8'(i), 4'b0001, 0, 0);
      for (int i = 0; i < 6; i++) drv(1, OP_XOR, 8'h20 + 8'(i), 4'b0100, 1, 0);
      check("pp_count", count, 2);
      for (int i = 0; i < 2; i++) drv(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 4; i++) drv(1, OP_OR, 8'h30 + 8'(i), 4'b0000, 0, 0);
      drv(1, OP_SHL, 8'h3F, 4'b1111, 1, 0);
      check("full_pop_count", count, 3);
      for (int i = 0; i < 3; i++) drv(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 300; i++) drv(1, OP_ADD, 8'(i), 4'b1000, 1, 0);
      check("ovf_sat", ovf_count, 8'hFF);
      drv(1, OP_PASS, 8'h00, 4'b0001, 1, 1);
      check("clr_push_sticky", sticky_flags, 4'b0001);
      check("clr_push_ovf", ovf_count, 0);
      drv(1, OP_ADD, 8'h55, 4'b1010, 1, 0);
      drv(0, 0, 0, 0, 1, 1);
      check("clr_sticky", sticky_flags, 0);
      repeat (200) drv($urandom_range(0, 1) == 1, 3'($urandom), 8'($urandom), 4'($urandom),
                       $urandom_range(0, 1) == 1, $urandom_range(0, 15) == 0);
      drv(0, 0, 0, 0, 0, 0);
      while (q.size() < 3) drv(1, OP_SHR, 8'($urandom), 4'b0110, 0, 0);
      while (q.size() > 3) drv(0, 0, 0, 0, 1, 0);
      in_valid = 0; out_ready = 0;
      #3 rst_n = 1'b0;
      #1;
      check("arst_count", count, 0);
      check("arst_out_valid", out_valid, 0);
      check("arst_in_ready", in_ready, 1);
      check("arst_sticky", sticky_flags, 0);
      check("arst_ovf", ovf_count, 0);
      q.delete(); sticky_m = '0; ovf_m = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      drv(1, OP_SUB, 8'hA5, 4'b0100, 0, 0);
      drv(0, 0, 0, 0, 1, 0);
      drv(0, 0, 0, 0, 1, 0);
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end
endmodule
